pts_sr_tx: RTL and testbench
============================

# pts_sr_tx

Parallel-to-serial transmitter that drives a serial-to-parallel receiver over a two-wire link (`serial_out`, `shift_enable`). It accepts a NUM_BITS word through a valid/ready load handshake and shifts it out MSB first, one bit per `bit_strobe`. Shifting MSB first means that after NUM_BITS enabled shifts, a receiver that shifts toward its MSB holds a copy of the loaded word. The block sits in front of the gradient-magnitude datapath's serial receivers and also serves as the stimulus source for their benches.

## Interface
- NUM_BITS, 4, word width; legal range 2..16.
- IDLE_LEVEL, 1'b1, level of `serial_out` whenever no bit is being sent; matches the receiver's all-ones reset state.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- parallel_in  in  NUM_BITS  word to send; sampled only on an accepted load.
- load_valid  in  1  producer offers `parallel_in` this cycle.
- load_ready  out  1  block can accept a word this cycle.
- bit_strobe  in  1  bit-rate tick; each high cycle in SHIFT sends one bit.
- serial_out  out  1  serial data to the receiver's `serial_in`.
- shift_enable  out  1  qualifies `serial_out`; drives the receiver's `shift_enable`.
- busy  out  1  high while a word is in flight (SHIFT).
- done  out  1  one-cycle pulse after the last bit has been shifted.

## Operation
- Registers:
  - state: IDLE, SHIFT, DONE.
  - tx_reg[NUM_BITS-1:0].
  - bit_cnt, width clog2(NUM_BITS+1).
- Reset (asynchronous, immediate, including mid-transfer):
  - state=IDLE, tx_reg=0, bit_cnt=0.
  - Outputs: load_ready=1, serial_out=IDLE_LEVEL, shift_enable=0, busy=0, done=0.
- IDLE:
  - load_ready=1, serial_out=IDLE_LEVEL.
  - On load_valid: tx_reg<=parallel_in, bit_cnt<=0, state<=SHIFT.
- SHIFT:
  - load_ready=0, busy=1.
  - serial_out=tx_reg[NUM_BITS-1]; this is combinational from registered state only and does not depend on `bit_strobe`.
  - shift_enable=bit_strobe.
  - On bit_strobe: tx_reg<=tx_reg<<1 (LSB filled with 0), bit_cnt<=bit_cnt+1.
  - If bit_cnt==NUM_BITS-1 on a strobe: state<=DONE.
  - Without a strobe, all registers hold and serial_out is stable.
- DONE:
  - done=1 for exactly this cycle; serial_out=IDLE_LEVEL, shift_enable=0.
  - load_ready=1. On load_valid: load as in IDLE and go to SHIFT. Otherwise go to IDLE.
- load_valid is ignored while load_ready=0. `parallel_in` changes during SHIFT have no effect.
- bit_strobe is ignored in IDLE and DONE.
- shift_enable is never high outside SHIFT. Exactly NUM_BITS shift_enable cycles occur per accepted word.

## Timing
- Load accepted at edge T0; first bit (MSB) appears on serial_out in cycle T0+1.
- Each shift_enable cycle: the receiver samples serial_out at the edge closing that cycle, and the transmitter advances to the next bit at the same edge.
- With bit_strobe held high: bits occupy T0+1..T0+NUM_BITS, done is high in T0+NUM_BITS+1, and load_ready is high again in that same cycle.
- Back-to-back words cost one idle-level bubble cycle (DONE) between words.
- Throughput: one word per NUM_BITS+1 cycles at full strobe rate.
- Latency from accepted load to done: NUM_BITS strobes + 1 cycle.

## Test plan
- Basic word:
  - Stimulus: NUM_BITS=4, parallel_in=4'b1010, bit_strobe=1 constant.
  - Required: serial_out=1,0,1,0 in cycles T0+1..T0+4 with shift_enable=1 in each; done=1 only in T0+5.
  - Required: a receiver model reset to 4'b1111 reads 4'b1010.
- Sparse strobe:
  - Stimulus: parallel_in=4'b0110, bit_strobe high every 3rd cycle.
  - Required: exactly 4 shift_enable pulses; serial_out constant between strobes; receiver reads 4'b0110; busy=1 for the whole transfer.
- Back-to-back:
  - Stimulus: load_valid held high with 4'hC, then 4'h3.
  - Required: second word accepted in the DONE cycle; one IDLE_LEVEL bubble with shift_enable=0 between words; receiver reads 4'hC, then 4'h3.
- Load while busy:
  - Stimulus: pulse load_valid with 4'hF during SHIFT of 4'h5.
  - Required: load_ready=0, the pulse is ignored, the 4'h5 bit sequence is unchanged, and no extra shift_enable occurs.
- Reset mid-transfer:
  - Stimulus: assert rst after 2 of 4 bits.
  - Required, immediately and asynchronously: serial_out=IDLE_LEVEL, shift_enable=0, busy=0, load_ready=1.
  - Required after release: a fresh load of 4'h9 is sent correctly.
- Strobe in IDLE:
  - Stimulus: bit_strobe toggling with load_valid=0.
  - Required: shift_enable stays 0, serial_out stays IDLE_LEVEL, done stays 0.

Source files
------------

// File: rtl/pts_sr_tx_if.sv
// Load handshake and two-wire serial link of the parallel-to-serial transmitter.
interface pts_sr_tx_if #(
   parameter int NUM_BITS = 4
);
   logic [NUM_BITS-1:0] parallel_in;
   logic                load_valid;
   logic                load_ready;
   logic                bit_strobe;
   logic                serial_out;
   logic                shift_enable;
   logic                busy;
   logic                done;

   modport master (
      output parallel_in,
      output load_valid,
      output bit_strobe,
      input  load_ready,
      input  serial_out,
      input  shift_enable,
      input  busy,
      input  done
   );

   modport slave (
      input  parallel_in,
      input  load_valid,
      input  bit_strobe,
      output load_ready,
      output serial_out,
      output shift_enable,
      output busy,
      output done
   );
endinterface

// File: rtl/pts_sr_tx.sv
// Parallel-to-serial transmitter: accepts a word on a valid/ready load and
// shifts it out MSB first, one bit per bit_strobe, qualified by shift_enable.
module pts_sr_tx #(
   parameter int   NUM_BITS   = 4,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input logic        clk,
   input logic        rst,
   pts_sr_tx_if.slave bus
);
   localparam int CW = $clog2(NUM_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t              state;
   logic [NUM_BITS-1:0] tx_reg;
   logic [CW-1:0]       bit_cnt;
   logic                ready_q;
   logic                busy_q;
   logic                done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tx_reg  <= '0;
         bit_cnt <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               // DONE accepts a new word too, giving a one-cycle bubble
               if (bus.load_valid) begin
                  tx_reg  <= bus.parallel_in;
                  bit_cnt <= '0;
                  state   <= SHIFT;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else begin
                  state   <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            SHIFT: begin
               if (bus.bit_strobe) begin
                  tx_reg  <= {tx_reg[NUM_BITS-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST) begin
                     state   <= DONE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Data depends only on registered state, so it is stable between strobes
   assign bus.serial_out   = (state == SHIFT) ? tx_reg[NUM_BITS-1] : IDLE_LEVEL;
   assign bus.shift_enable = (state == SHIFT) & bus.bit_strobe;
   assign bus.load_ready   = ready_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
endmodule

// File: tb/tb_pts_sr_tx.sv
// Directed bench for pts_sr_tx with a receiver model that shifts toward its MSB.
module tb_pts_sr_tx;
   logic clk;
   logic rst;
   logic rx_clr;
   logic [3:0] rx;
   int vectors;
   int miscompares;

   pts_sr_tx_if #(.NUM_BITS(4)) bus ();

   pts_sr_tx #(
      .NUM_BITS(4),
      .IDLE_LEVEL(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst || rx_clr)
         rx <= 4'hF;
      else if (bus.shift_enable)
         rx <= {rx[2:0], bus.serial_out};
   end

   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // Called in the first SHIFT cycle with bit_strobe held high
   task automatic run_word(input string tag, input logic [3:0] w);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk({tag, "_bit"}, 16'(bus.serial_out), 16'(w[3-i]));
         chk({tag, "_se"}, 16'(bus.shift_enable), 16'd1);
         chk({tag, "_busy"}, 16'(bus.busy), 16'd1);
         chk({tag, "_rdy"}, 16'(bus.load_ready), 16'd0);
         chk({tag, "_done0"}, 16'(bus.done), 16'd0);
         nxt();
      end
      settle();
      chk({tag, "_done"}, 16'(bus.done), 16'd1);
      chk({tag, "_done_ser"}, 16'(bus.serial_out), 16'd1);
      chk({tag, "_done_se"}, 16'(bus.shift_enable), 16'd0);
      chk({tag, "_done_rdy"}, 16'(bus.load_ready), 16'd1);
      chk({tag, "_rx"}, 16'(rx), 16'(w));
   endtask

   initial begin
      int se_cnt;
      int k;
      logic [3:0] w;
      logic prev_ser;
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      rx_clr = 1'b0;
      bus.parallel_in = 4'h0;
      bus.load_valid = 1'b0;
      bus.bit_strobe = 1'b0;

      #2;
      chk("rst_rdy", 16'(bus.load_ready), 16'd1);
      chk("rst_ser", 16'(bus.serial_out), 16'd1);
      chk("rst_se", 16'(bus.shift_enable), 16'd0);
      chk("rst_busy", 16'(bus.busy), 16'd0);
      chk("rst_done", 16'(bus.done), 16'd0);
      nxt();
      nxt();
      rst = 1'b0;

      // Basic word 1010, strobe always high
      nxt();
      bus.bit_strobe = 1'b1;
      bus.load_valid = 1'b1;
      bus.parallel_in = 4'b1010;
      rx_clr = 1'b1;
      settle();
      chk("basic_rdy", 16'(bus.load_ready), 16'd1);
      nxt();
      bus.load_valid = 1'b0;
      rx_clr = 1'b0;
      run_word("basic", 4'b1010);
      nxt();
      settle();
      chk("basic_idle_done", 16'(bus.done), 16'd0);
      chk("basic_idle_se", 16'(bus.shift_enable), 16'd0);

      // Sparse strobe: one strobe every third cycle
      bus.bit_strobe = 1'b0;
      bus.load_valid = 1'b1;
      bus.parallel_in = 4'b0110;
      rx_clr = 1'b1;
      nxt();
      bus.load_valid = 1'b0;
      bus.parallel_in = 4'b1001;
      rx_clr = 1'b0;
      w = 4'b0110;
      k = 0;
      se_cnt = 0;
      prev_ser = 1'b0;
      for (int c = 0; c < 12; c++) begin
         bus.bit_strobe = (c % 3 == 2);
         settle();
         chk("sparse_bit", 16'(bus.serial_out), 16'(w[3-k]));
         chk("sparse_busy", 16'(bus.busy), 16'd1);
         if (c % 3 != 0)
            chk("sparse_stable", 16'(bus.serial_out), 16'(prev_ser));
         prev_ser = bus.serial_out;
         if (bus.shift_enable)
            se_cnt++;
         if (c % 3 == 2)
            k++;
         nxt();
      end
      bus.bit_strobe = 1'b0;
      settle();
      chk("sparse_se_cnt", 16'(se_cnt), 16'd4);
      chk("sparse_done", 16'(bus.done), 16'd1);
      chk("sparse_rx", 16'(rx), 16'h6);

      // Back-to-back: load_valid held through the DONE cycle
      nxt();
      bus.bit_strobe = 1'b1;
      bus.load_valid = 1'b1;
      bus.parallel_in = 4'hC;
      nxt();
      bus.parallel_in = 4'h3;
      run_word("b2b_c", 4'hC);
      nxt();
      bus.load_valid = 1'b0;
      run_word("b2b_3", 4'h3);

      // Load pulse while busy is ignored
      nxt();
      bus.load_valid = 1'b1;
      bus.parallel_in = 4'h5;
      nxt();
      bus.load_valid = 1'b0;
      se_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         bus.load_valid = (i == 1);
         bus.parallel_in = (i == 1) ? 4'hF : 4'h5;
         settle();
         chk("busy_rdy", 16'(bus.load_ready), 16'd0);
         chk("busy_bit", 16'(bus.serial_out), 16'(i == 1 || i == 3));
         if (bus.shift_enable)
            se_cnt++;
         nxt();
      end
      bus.load_valid = 1'b0;
      settle();
      chk("busy_done", 16'(bus.done), 16'd1);
      chk("busy_rx", 16'(rx), 16'h5);
      nxt();
      settle();
      chk("busy_after_busy", 16'(bus.busy), 16'd0);
      chk("busy_after_se", 16'(bus.shift_enable), 16'd0);
      if (bus.shift_enable)
         se_cnt++;
      chk("busy_se_cnt", 16'(se_cnt), 16'd4);

      // Reset mid-transfer, then a fresh word
      bus.load_valid = 1'b1;
      bus.parallel_in = 4'hA;
      nxt();
      bus.load_valid = 1'b0;
      nxt();
      nxt();
      settle();
      chk("mid_pre_busy", 16'(bus.busy), 16'd1);
      rst = 1'b1;
      #1;
      chk("mid_ser", 16'(bus.serial_out), 16'd1);
      chk("mid_se", 16'(bus.shift_enable), 16'd0);
      chk("mid_busy", 16'(bus.busy), 16'd0);
      chk("mid_rdy", 16'(bus.load_ready), 16'd1);
      nxt();
      rst = 1'b0;
      nxt();
      bus.load_valid = 1'b1;
      bus.parallel_in = 4'h9;
      nxt();
      bus.load_valid = 1'b0;
      run_word("after_rst", 4'h9);

      // Strobe toggling in IDLE
      nxt();
      for (int i = 0; i < 6; i++) begin
         bus.bit_strobe = i[0];
         settle();
         chk("idle_se", 16'(bus.shift_enable), 16'd0);
         chk("idle_ser", 16'(bus.serial_out), 16'd1);
         chk("idle_done", 16'(bus.done), 16'd0);
         nxt();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
